// File: rtl/cursor_tracker_if.sv
// Motion-packet handshake between the mouse decoder (master) and the cursor tracker (slave).
interface cursor_tracker_if;
   logic              pkt_valid;
   logic              pkt_ready;
   logic signed [8:0] pkt_dx;
   logic signed [8:0] pkt_dy;
   logic              pkt_btn;

   modport master (output pkt_valid, pkt_dx, pkt_dy, pkt_btn, input pkt_ready);
   modport slave  (input pkt_valid, pkt_dx, pkt_dy, pkt_btn, output pkt_ready);
endinterface

// File: rtl/cursor_tracker.sv
// Accumulates relative mouse motion per frame and commits a clamped cursor position at vblank.
// Outputs move once per frame_tick (commit cycle closes one edge after the tick is sampled); pkt_ready drops only in that cycle.
module cursor_tracker #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int MARGIN      = 8,
   parameter int X_INIT      = 320,
   parameter int Y_INIT      = 240,
   parameter int HIDE_FRAMES = 120,
   parameter int SLASH_MIN   = 4
) (
   input  logic             clk,
   input  logic             rst,
   cursor_tracker_if.slave  pkt,
   input  logic             frame_tick,
   output logic [9:0]       x0,
   output logic [9:0]       y0,
   output logic             en,
   output logic             slash
);
   localparam int IW = $clog2(HIDE_FRAMES + 1);

   localparam logic signed [12:0] P_MAX = 13'sd2047;
   localparam logic signed [12:0] P_MIN = -13'sd2048;
   localparam logic signed [12:0] X_LO  = 13'(MARGIN);
   localparam logic signed [12:0] X_HI  = 13'(H_RES - 1 - MARGIN);
   localparam logic signed [12:0] Y_LO  = 13'(MARGIN);
   localparam logic signed [12:0] Y_HI  = 13'(V_RES - 1 - MARGIN);
   localparam logic [12:0]        SMIN  = 13'(SLASH_MIN);
   localparam logic [IW-1:0]      HMAX  = IW'(HIDE_FRAMES);

   typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

   state_t             state;
   logic signed [11:0] pend_dx;
   logic signed [11:0] pend_dy;
   logic               btn_seen;
   logic [IW-1:0]      idle_cnt;

   logic               accept;
   logic signed [12:0] nx;
   logic signed [12:0] ny;
   logic [12:0]        mag;
   logic               moved;
   logic [IW-1:0]      idle_next;

   function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic signed [8:0]  b);
      logic signed [12:0] s;
      s = $signed({a[11], a}) + $signed({{4{b[8]}}, b});
      if (s > P_MAX)      return P_MAX[11:0];
      else if (s < P_MIN) return P_MIN[11:0];
      else                return s[11:0];
   endfunction

   function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] lo,
                                        input logic signed [12:0] hi);
      if (v < lo)      return lo[9:0];
      else if (v > hi) return hi[9:0];
      else             return v[9:0];
   endfunction

   function automatic logic [12:0] abs12(input logic signed [11:0] v);
      logic signed [12:0] e;
      e = {v[11], v};
      return e[12] ? -e : e;
   endfunction

   // COMMIT owns the pending registers for one cycle, so no packet may land there.
   assign pkt.pkt_ready = (state != COMMIT) && !rst;
   assign accept        = pkt.pkt_valid && pkt.pkt_ready;

   assign nx        = $signed({3'b000, x0}) + $signed({pend_dx[11], pend_dx});
   assign ny        = $signed({3'b000, y0}) - $signed({pend_dy[11], pend_dy});
   assign mag       = abs12(pend_dx) + abs12(pend_dy);
   assign moved     = (pend_dx != 12'sd0) || (pend_dy != 12'sd0) || btn_seen;
   assign idle_next = (idle_cnt == HMAX) ? HMAX : idle_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         x0       <= 10'(X_INIT);
         y0       <= 10'(Y_INIT);
         en       <= 1'b1;
         slash    <= 1'b0;
         pend_dx  <= '0;
         pend_dy  <= '0;
         btn_seen <= 1'b0;
         idle_cnt <= '0;
      end else begin
         if (accept) begin
            pend_dx  <= sat_add(pend_dx, pkt.pkt_dx);
            pend_dy  <= sat_add(pend_dy, pkt.pkt_dy);
            btn_seen <= btn_seen | pkt.pkt_btn;
         end
         case (state)
            IDLE: begin
               if (frame_tick)  state <= COMMIT;
               else if (accept) state <= ACCUM;
            end
            ACCUM: begin
               if (frame_tick) state <= COMMIT;
            end
            COMMIT: begin
               state    <= IDLE;
               // Screen Y grows downward while mouse +dy means up.
               x0       <= clamp(nx, X_LO, X_HI);
               y0       <= clamp(ny, Y_LO, Y_HI);
               slash    <= btn_seen && (mag >= SMIN);
               if (moved) begin
                  idle_cnt <= '0;
                  en       <= 1'b1;
               end else begin
                  idle_cnt <= idle_next;
                  en       <= (idle_next != HMAX);
               end
               pend_dx  <= '0;
               pend_dy  <= '0;
               btn_seen <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cursor_tracker.sv
// Directed bench for cursor_tracker: hand-computed cursor positions, clamps, slash and hide timing.
module tb_cursor_tracker;
   logic       clk;
   logic       rst;
   logic       frame_tick;
   logic [9:0] x0;
   logic [9:0] y0;
   logic       en;
   logic       slash;

   int checks   = 0;
   int failures = 0;

   cursor_tracker_if pkt_if ();

   cursor_tracker dut (
      .clk        (clk),
      .rst        (rst),
      .pkt        (pkt_if),
      .frame_tick (frame_tick),
      .x0         (x0),
      .y0         (y0),
      .en         (en),
      .slash      (slash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int dx, input int dy, input logic btn);
      int n;
      pkt_if.pkt_valid = 1'b1;
      pkt_if.pkt_dx    = 9'(dx);
      pkt_if.pkt_dy    = 9'(dy);
      pkt_if.pkt_btn   = btn;
      n = 0;
      while (!pkt_if.pkt_ready && n < 8) begin
         step();
         n++;
      end
      if (n == 8) chk("send_ready_timeout", 0, 1);
      step();
      pkt_if.pkt_valid = 1'b0;
      pkt_if.pkt_btn   = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      rst              = 1'b1;
      frame_tick       = 1'b0;
      pkt_if.pkt_valid = 1'b0;
      pkt_if.pkt_dx    = '0;
      pkt_if.pkt_dy    = '0;
      pkt_if.pkt_btn   = 1'b0;

      // T1 reset
      step();
      step();
      chk("rst_ready", pkt_if.pkt_ready, 0);
      chk("rst_x0", x0, 320);
      chk("rst_y0", y0, 240);
      chk("rst_en", en, 1);
      chk("rst_slash", slash, 0);
      rst = 1'b0;
      #1;
      chk("rel_ready", pkt_if.pkt_ready, 1);
      step();

      // T2 accumulation, Y inversion, commit timing
      send(10, 5, 1'b0);
      send(-3, 0, 1'b0);
      chk("t2_pre_x0", x0, 320);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("t2_tickedge_x0", x0, 320);
      chk("t2_tickedge_y0", y0, 240);
      step();
      chk("t2_x0", x0, 327);
      chk("t2_y0", y0, 235);

      // Reset mid-frame discards pending motion
      send(50, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_x0", x0, 320);
      chk("midrst_y0", y0, 240);
      step();
      rst = 1'b0;
      tick();
      chk("midrst_commit_x0", x0, 320);

      // T3 clamps
      for (int i = 0; i < 3; i++) send(-255, 0, 1'b0);
      tick();
      chk("t3_xlo", x0, 8);
      for (int i = 0; i < 2; i++) send(255, 0, 1'b0);
      tick();
      chk("t3_x518", x0, 518);
      for (int i = 0; i < 2; i++) send(255, 0, 1'b0);
      tick();
      chk("t3_xhi", x0, 631);
      send(255, 0, 1'b0);
      tick();
      chk("t3_xhi_hold", x0, 631);
      for (int i = 0; i < 2; i++) send(0, -255, 1'b0);
      tick();
      chk("t3_yhi", y0, 471);
      for (int i = 0; i < 2; i++) send(0, 255, 1'b0);
      tick();
      chk("t3_ylo", y0, 8);
      // Pending saturation: 9 x -256 = -2304 saturates to -2048 (a wrap would give +1792)
      for (int i = 0; i < 9; i++) send(-256, 0, 1'b0);
      tick();
      chk("t3_sat_neg", x0, 8);
      // 9 x 255 = 2295 saturates to 2047 (a wrap would give -1801)
      for (int i = 0; i < 9; i++) send(255, 0, 1'b0);
      tick();
      chk("t3_sat_pos", x0, 631);

      // T4 packet coincident with frame_tick; ready low only in COMMIT
      pkt_if.pkt_valid = 1'b1;
      pkt_if.pkt_dx    = -9'sd5;
      pkt_if.pkt_dy    = '0;
      frame_tick       = 1'b1;
      chk("t4_ready_tick", pkt_if.pkt_ready, 1);
      step();
      frame_tick       = 1'b0;
      pkt_if.pkt_dx    = -9'sd7;
      chk("t4_ready_commit", pkt_if.pkt_ready, 0);
      step();
      chk("t4_x0", x0, 626);
      chk("t4_ready_after", pkt_if.pkt_ready, 1);
      step();
      pkt_if.pkt_valid = 1'b0;
      tick();
      chk("t4_held_pkt_x0", x0, 619);

      // T5 slash gesture
      send(2, 2, 1'b1);
      tick();
      chk("t5_slash_set", slash, 1);
      chk("t5_x0", x0, 621);
      tick();
      chk("t5_slash_idle", slash, 0);
      send(1, 1, 1'b1);
      tick();
      chk("t5_slash_small", slash, 0);
      send(-2, -2, 1'b1);
      tick();
      chk("t5_slash_neg", slash, 1);
      send(20, 0, 1'b0);
      tick();
      chk("t5_slash_nobtn", slash, 0);

      // T6 hide after idle frames
      for (int i = 0; i < 119; i++) tick();
      chk("t6_en_119", en, 1);
      tick();
      chk("t6_en_120", en, 0);
      tick();
      chk("t6_en_121", en, 0);
      send(1, 0, 1'b0);
      chk("t6_en_pre", en, 0);
      tick();
      chk("t6_en_back", en, 1);
      chk("t6_x0", x0, 631);
      for (int i = 0; i < 120; i++) tick();
      chk("t6_en_hidden2", en, 0);
      send(0, 0, 1'b1);
      tick();
      chk("t6_en_btn", en, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
